iob_eth_tx_sched: RTL and testbench

Round-robin scheduler that shares the single Ethernet TX engine between N_REQ frame requesters in the CPU clock domain. It arbitrates requests, validates frame length, and drives the engine's send/nbytes inputs. It selects which requester's frame buffer feeds the engine, tracks completion through the engine's TX_CLK-domain ready flag, and enforces an inter-frame gap and a hang timeout.

---
 rtl/iob_eth_tx_sched.sv | 180 ++++++++++++++++++
 tb/tb_iob_eth_tx_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_tx_sched.sv
// Round-robin scheduler sharing one Ethernet TX engine between N_REQ
// requesters. It arbitrates among the requests, rejects illegal frame
// lengths, and drives the engine send/nbytes inputs. Completion is tracked
// through the engine's asynchronous ready flag. The block also enforces an
// inter-frame gap and a per-frame hang timeout.
//
// Ports:
//   clk, rst_n   CPU clock, asynchronous active-low reset
//   req          per-requester frame request level
//   nbytes_in    packed lengths, requester i at [i*NBYTES_W +: NBYTES_W]
//   grant        one-hot, high from launch until done/err
//   done, err    1-cycle one-hot pulses: frame completed / rejected or timed out
//   tx_sel       index of the granted requester (buffer mux select)
//   tx_nbytes    registered frame length to the engine
//   tx_send      send request to the engine
//   tx_ready     engine ready, asynchronous to clk
//   busy         high whenever the scheduler is not idle
module iob_eth_tx_sched #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned NBYTES_W       = 11,
  parameter int unsigned MAX_NBYTES     = 1500,
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned SEL_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*NBYTES_W-1:0] nbytes_in,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic [SEL_W-1:0]          tx_sel,
  output logic [NBYTES_W-1:0]       tx_nbytes,
  output logic                      tx_send,
  input  logic                      tx_ready,
  output logic                      busy
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IFG_LOAD = CNT_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

  state_t               state_q, state_d;
  logic                 ready_m, ready_s;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]     grant_d, done_d, err_d;
  logic [SEL_W-1:0]     tx_sel_d;
  logic [NBYTES_W-1:0]  tx_nbytes_d;
  logic                 tx_send_d, busy_d;

  logic                 win_vld;
  logic [SEL_W-1:0]     win;
  logic [NBYTES_W-1:0]  win_len;
  logic                 len_bad;
  int                   idx;

  // Two-flop synchronizer; ready resets high so an idle engine is assumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {ready_s, ready_m} <= 2'b11;
    else        {ready_s, ready_m} <= {ready_m, tx_ready};
  end

  // Round-robin search: first set request strictly after the pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(N_REQ);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = SEL_W'(idx);
      end
    end
  end

  // Length of the winning requester and its legality.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win == SEL_W'(i)) win_len = nbytes_in[i*NBYTES_W +: NBYTES_W];
    end
    len_bad = (win_len == '0) || (32'(win_len) > MAX_NBYTES);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= SEL_W'(N_REQ - 1);
      cnt_q     <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      tx_sel    <= '0;
      tx_nbytes <= '0;
      tx_send   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant     <= grant_d;
      done      <= done_d;
      err       <= err_d;
      tx_sel    <= tx_sel_d;
      tx_nbytes <= tx_nbytes_d;
      tx_send   <= tx_send_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic. cnt_q is the timeout counter in
  // START/RUN and the gap counter in GAP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant;
    done_d      = '0;
    err_d       = '0;
    tx_sel_d    = tx_sel;
    tx_nbytes_d = tx_nbytes;
    tx_send_d   = tx_send;
    busy_d      = busy;
    unique case (state_q)
      IDLE: begin
        if (ready_s && win_vld) begin
          ptr_d       = win;
          tx_sel_d    = win;
          tx_nbytes_d = win_len;
          if (len_bad) begin
            err_d = N_REQ'(1) << win;
          end else begin
            grant_d   = N_REQ'(1) << win;
            tx_send_d = 1'b1;
            busy_d    = 1'b1;
            cnt_d     = '0;
            state_d   = START;
          end
        end
      end
      START, RUN: begin
        if (state_q == RUN && ready_s) begin
          done_d  = N_REQ'(1) << tx_sel;
          grant_d = '0;
          cnt_d   = IFG_LOAD;
          state_d = GAP;
        end else if (cnt_q == TMO_LAST) begin
          // Engine hung: abort without a done pulse.
          err_d     = N_REQ'(1) << tx_sel;
          grant_d   = '0;
          tx_send_d = 1'b0;
          cnt_d     = IFG_LOAD;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == START && !ready_s) begin
            tx_send_d = 1'b0;
            state_d   = RUN;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_eth_tx_sched.sv
// Scoreboard bench for iob_eth_tx_sched. Stimulus pushes the expected
// launches and the expected done/err pulses into queues. A monitor thread
// pops an entry and compares it whenever grant rises or done/err pulses.
// The engine model runs on an unrelated 25 MHz clock.
module tb_iob_eth_tx_sched;
  localparam int unsigned N    = 2;
  localparam int unsigned NW   = 11;
  localparam int unsigned MAXN = 1500;
  localparam int unsigned IFG  = 12;
  localparam int unsigned TMO  = 300;

  logic            clk = 1'b0, eng_clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*NW-1:0] nbytes_in = '0;
  logic [N-1:0]    grant, done, err;
  logic [0:0]      tx_sel;
  logic [NW-1:0]   tx_nbytes;
  logic            tx_send, busy;
  logic            tx_ready = 1'b1;

  iob_eth_tx_sched #(
    .N_REQ(N), .NBYTES_W(NW), .MAX_NBYTES(MAXN),
    .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .nbytes_in(nbytes_in),
    .grant(grant), .done(done), .err(err), .tx_sel(tx_sel),
    .tx_nbytes(tx_nbytes), .tx_send(tx_send), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  initial begin
    #($urandom_range(39, 1));
    forever #20 eng_clk = ~eng_clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: drops ready 3 engine cycles after it sees send, holds it
  // low for a programmable or random number of cycles, then raises it.
  logic send_m = 1'b0, send_s = 1'b0;
  int   es = 0, ec = 0, low_cur = 10, eng_low = 10;
  bit   eng_hang = 1'b0, eng_rand = 1'b0;
  always @(posedge eng_clk) begin
    send_m <= tx_send;
    send_s <= send_m;
    case (es)
      0: if (send_s && !eng_hang) begin
           es <= 1; ec <= 0;
           low_cur <= eng_rand ? int'($urandom_range(40, 3)) : eng_low;
         end
      1: if (ec == 2) begin tx_ready <= 1'b0; es <= 2; ec <= 0; end
         else ec <= ec + 1;
      2: if (ec >= low_cur - 1) begin tx_ready <= 1'b1; es <= 3; end
         else ec <= ec + 1;
      default: if (!send_s) es <= 0;
    endcase
  end

  typedef struct { int idx; int nb; } launch_t;
  typedef struct { bit is_err; int idx; int lat; } comp_t;
  launch_t lq[$];
  comp_t   cq[$];

  int vec = 0, miss = 0, n_comp = 0;
  int launch_cyc = 0, end_cyc = 0;
  bit have_end = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [N-1:0] pg;
    launch_t l;
    comp_t   c;
    pg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_end = 1'b0;
        pg = '0;
      end else begin
        if (grant != '0 && pg == '0) begin
          if (lq.size() == 0) check("unexpected_launch", 32'(grant), 0);
          else begin
            l = lq.pop_front();
            check("launch_grant", 32'(grant), 32'(1) << l.idx);
            check("launch_nbytes", 32'(tx_nbytes), l.nb);
            check("launch_sel", 32'(tx_sel), l.idx);
            check("launch_send_busy", 32'({tx_send, busy}), 3);
            if (have_end) check("launch_after_gap", 32'(cyc - end_cyc >= int'(IFG) + 1), 1);
            launch_cyc = cyc;
          end
        end
        if (done != '0 || err != '0) begin
          if (cq.size() == 0) check("unexpected_done_err", 32'({done, err}), 0);
          else begin
            c = cq.pop_front();
            n_comp++;
            check("done_vec", 32'(done), c.is_err ? 0 : 32'(1) << c.idx);
            check("err_vec", 32'(err), c.is_err ? 32'(1) << c.idx : 0);
            check("end_grant_send", 32'({grant, tx_send}), 0);
            if (c.lat >= 0) check("timeout_latency", cyc - launch_cyc, c.lat);
            if (!c.is_err || c.lat >= 0) begin
              have_end = 1'b1;
              end_cyc  = cyc;
            end
          end
        end
        pg = grant;
      end
    end
  endtask

  task automatic set_len(input int i, input int v);
    nbytes_in[i*NW +: NW] = NW'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int budget, input string nm);
    int k = 0;
    while (grant == '0 && k < budget) begin @(negedge clk); k++; end
    if (grant == '0) check(nm, 0, 1);
  endtask

  task automatic wait_comp(input int target, input int budget, input string nm);
    int k = 0;
    while (n_comp < target && k < budget) begin @(negedge clk); k++; end
    if (n_comp < target) check(nm, n_comp, target);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    if (busy) check(nm, 1, 0);
  endtask

  initial begin
    int base;
    fork monitor(); join_none

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_outputs", 32'({grant, done, err, tx_send, busy, tx_sel, tx_nbytes}), 0);

    // Single frame, 1-cycle grant latency, gap back to idle
    base = n_comp;
    set_len(0, 64);
    eng_low = 50;
    lq.push_back('{0, 64});
    cq.push_back('{1'b0, 0, -1});
    req = 2'b01;
    @(negedge clk);
    check("grant_latency", 32'(grant), 1);
    req = 2'b00;
    wait_comp(base + 1, 1000, "single_done_wait");
    wait_idle(100, "single_idle_wait");
    check("gap_to_idle", cyc - end_cyc, IFG);

    // Bad lengths 0 and 1501, then pointer moves on, then 1500 is legal
    do_reset();
    base = n_comp;
    set_len(1, 0);
    cq.push_back('{1'b1, 1, -1});
    req = 2'b10;
    @(negedge clk);
    req = 2'b00;
    check("badlen0_no_send", 32'({tx_send, busy}), 0);
    @(negedge clk);
    set_len(1, 1501);
    cq.push_back('{1'b1, 1, -1});
    req = 2'b10;
    @(negedge clk);
    req = 2'b00;
    check("badlen1501_no_send", 32'({tx_send, busy}), 0);
    repeat (3) @(negedge clk);
    set_len(0, 50);
    lq.push_back('{0, 50});
    cq.push_back('{1'b0, 0, -1});
    req = 2'b11;
    wait_grant(20, "after_bad_grant_wait");
    req = 2'b00;
    wait_comp(base + 3, 1000, "after_bad_done_wait");
    wait_idle(100, "after_bad_idle_wait");
    set_len(1, 1500);
    lq.push_back('{1, 1500});
    cq.push_back('{1'b0, 1, -1});
    req = 2'b10;
    wait_grant(20, "max_len_grant_wait");
    req = 2'b00;
    wait_comp(base + 4, 1000, "max_len_done_wait");
    wait_idle(100, "max_len_idle_wait");

    // Hang timeout: engine never drops ready
    do_reset();
    base = n_comp;
    eng_hang = 1'b1;
    set_len(0, 80);
    lq.push_back('{0, 80});
    cq.push_back('{1'b1, 0, int'(TMO)});
    req = 2'b01;
    wait_grant(20, "tmo_grant_wait");
    req = 2'b00;
    wait_comp(base + 1, int'(TMO) + 50, "tmo_err_wait");
    wait_idle(100, "tmo_idle_wait");
    check("tmo_gap_to_idle", cyc - end_cyc, IFG);
    eng_hang = 1'b0;

    // Contention with random engine timing: strict alternation over 50 frames
    do_reset();
    base = n_comp;
    eng_rand = 1'b1;
    set_len(0, 100);
    set_len(1, 200);
    for (int f = 0; f < 50; f++) begin
      lq.push_back('{f % 2, (f % 2 == 1) ? 200 : 100});
      cq.push_back('{1'b0, f % 2, -1});
    end
    req = 2'b11;
    wait_comp(base + 50, 50 * 400, "contention_done_wait");
    req = 2'b00;
    wait_idle(100, "contention_idle_wait");
    eng_rand = 1'b0;

    // Reset in the middle of RUN: no pulses, requester 0 first afterwards
    do_reset();
    base = n_comp;
    eng_low = 50;
    set_len(1, 70);
    lq.push_back('{1, 70});
    req = 2'b10;
    wait_grant(20, "midrun_grant_wait");
    req = 2'b00;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset_outputs", 32'({grant, done, err, tx_send, busy, tx_sel, tx_nbytes}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int k = 0;
      while (!tx_ready && k < 500) begin @(negedge clk); k++; end
      if (!tx_ready) check("engine_ready_wait", 0, 1);
    end
    repeat (10) @(negedge clk);
    set_len(0, 60);
    lq.push_back('{0, 60});
    cq.push_back('{1'b0, 0, -1});
    req = 2'b11;
    wait_grant(20, "post_reset_grant_wait");
    req = 2'b00;
    wait_comp(base + 1, 1000, "post_reset_done_wait");
    wait_idle(100, "post_reset_idle_wait");

    repeat (20) @(negedge clk);
    check("launch_queue_empty", lq.size(), 0);
    check("comp_queue_empty", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
